mem_wb_stage: RTL and testbench

Parametrised MEM→WB pipeline stage for the five-stage core. It replaces the free-running MEM/WB register with a ready/valid stage that supports flush and synchronous reset. The writeback result is selected at capture time, so the register-file write port and the forwarding network read one registered value. It sits between the data-memory stage and register-file writeback, and also feeds the EX-stage forwarding mux.

---
 rtl/core_pkg.sv | 27 ++
 rtl/pipe_skid.sv | 40 ++++
 rtl/mem_wb_stage.sv | 133 +++++++++++++
 tb/tb_mem_wb_stage.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared core types: result-source encoding, datapath width defaults and the
// MEM/WB writeback entry carried through the stage and its optional skid.
package core_pkg;

  localparam int XLEN_DEF = 32;
  localparam int RAW_DEF  = 5;
  localparam int RSW_DEF  = 2;

  typedef enum logic [1:0] {
    RES_ALU = 2'b00,
    RES_MEM = 2'b01,
    RES_PC4 = 2'b10,
    RES_RSV = 2'b11
  } res_src_e;

  typedef struct packed {
    logic                regw;
    logic [RAW_DEF-1:0]  rd;
    logic [XLEN_DEF-1:0] wb_data;
  } wb_entry_t;

  // Writeback enable with x0 writes squashed, since x0 is hardwired to zero.
  function automatic logic regw_qualify(input logic regw, input logic is_x0);
    return regw && !is_x0;
  endfunction

endpackage

// File: rtl/pipe_skid.sv
// Generic one-entry skid register. ready is registered and equals "skid empty",
// so it falls the cycle after the entry fills.
module pipe_skid
  import core_pkg::*;
#(
  parameter type T = wb_entry_t
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic load,
  input  T     din,
  input  logic unload,
  output logic valid,
  output T     dout,
  output logic ready
);

  // Skid storage: clear drops the entry but keeps the stale payload.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid <= 1'b0;
      dout  <= T'(0);
      ready <= 1'b0;
    end else if (clr) begin
      valid <= 1'b0;
      ready <= 1'b1;
    end else if (load) begin
      valid <= 1'b1;
      dout  <= din;
      ready <= 1'b0;
    end else if (unload) begin
      valid <= 1'b0;
      ready <= 1'b1;
    end else begin
      ready <= !valid;
    end
  end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM->WB ready/valid pipeline stage with writeback-result selection at capture.
// Optional feature macro: MEM_WB_SKID_EN adds a one-entry skid with registered in_ready.
module mem_wb_stage
  import core_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int RAW  = RAW_DEF,
  parameter int RSW  = RSW_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            flush,
  input  logic            regw_i,
  input  logic [RSW-1:0]  resrc_i,
  input  logic [XLEN-1:0] alu_i,
  input  logic [XLEN-1:0] memd_i,
  input  logic [XLEN-1:0] pcp4_i,
  input  logic [RAW-1:0]  rd_i,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            regw_o,
  output logic [RAW-1:0]  rd_o,
  output logic [XLEN-1:0] wb_data_o,
  output logic            fwd_en_o,
  output logic [RAW-1:0]  fwd_rd_o,
  output logic [XLEN-1:0] fwd_data_o
);

  typedef struct packed {
    logic            regw;
    logic [RAW-1:0]  rd;
    logic [XLEN-1:0] wb_data;
  } stage_entry_t;

  stage_entry_t entry_in;
  stage_entry_t main_q;
  logic         main_valid;
  logic         capture;
  logic [XLEN-1:0] sel_data;

  // Result mux; the reserved encoding falls back to the ALU result.
  always_comb begin
    sel_data = alu_i;
    case (res_src_e'(resrc_i[1:0]))
      RES_ALU: sel_data = alu_i;
      RES_MEM: sel_data = memd_i;
      RES_PC4: sel_data = pcp4_i;
      RES_RSV: sel_data = alu_i;
      default: sel_data = alu_i;
    endcase
  end

  assign entry_in.regw    = regw_qualify(regw_i, (rd_i == {RAW{1'b0}}));
  assign entry_in.rd      = rd_i;
  assign entry_in.wb_data = sel_data;

  assign capture = in_valid && in_ready;

`ifdef MEM_WB_SKID_EN
  logic         skid_valid;
  logic         skid_ready;
  logic         skid_load;
  logic         skid_unload;
  stage_entry_t skid_q;

  // Main register full and stalled: the accepted input parks in the skid.
  assign skid_load   = capture && main_valid && !out_ready;
  assign skid_unload = skid_valid && out_ready;
  assign in_ready    = skid_ready;

  pipe_skid #(.T(stage_entry_t)) u_skid (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (flush),
    .load   (skid_load),
    .din    (entry_in),
    .unload (skid_unload),
    .valid  (skid_valid),
    .dout   (skid_q),
    .ready  (skid_ready)
  );

  // Main register: direct capture, refill from skid, or drain on consume.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      main_valid <= 1'b0;
      main_q     <= stage_entry_t'(0);
    end else if (flush) begin
      main_valid <= 1'b0;
    end else if (capture && !skid_load) begin
      main_valid <= 1'b1;
      main_q     <= entry_in;
    end else if (skid_unload) begin
      main_valid <= 1'b1;
      main_q     <= skid_q;
    end else if (out_ready) begin
      main_valid <= 1'b0;
    end else begin
      main_valid <= main_valid;
    end
  end
`else
  assign in_ready = rst_n && (!main_valid || out_ready);

  // Main register: capture wins over consume so back-to-back has no bubble.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      main_valid <= 1'b0;
      main_q     <= stage_entry_t'(0);
    end else if (flush) begin
      main_valid <= 1'b0;
    end else if (capture) begin
      main_valid <= 1'b1;
      main_q     <= entry_in;
    end else if (out_ready) begin
      main_valid <= 1'b0;
    end else begin
      main_valid <= main_valid;
    end
  end
`endif

  assign out_valid  = main_valid;
  assign regw_o     = main_q.regw;
  assign rd_o       = main_q.rd;
  assign wb_data_o  = main_q.wb_data;
  assign fwd_en_o   = main_valid && main_q.regw;
  assign fwd_rd_o   = main_q.rd;
  assign fwd_data_o = main_q.wb_data;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Scoreboard bench for mem_wb_stage: directed stimulus pushes expected entries,
// a negedge monitor pops and compares on every consumed output.
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, flush;
  logic        regw_i;
  logic [1:0]  resrc_i;
  logic [31:0] alu_i, memd_i, pcp4_i;
  logic [4:0]  rd_i;
  logic        out_valid, out_ready, regw_o, fwd_en_o;
  logic [4:0]  rd_o, fwd_rd_o;
  logic [31:0] wb_data_o, fwd_data_o;

  typedef struct {
    logic        regw;
    logic [4:0]  rd;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;

  mem_wb_stage dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .flush(flush), .regw_i(regw_i), .resrc_i(resrc_i), .alu_i(alu_i),
    .memd_i(memd_i), .pcp4_i(pcp4_i), .rd_i(rd_i), .out_valid(out_valid),
    .out_ready(out_ready), .regw_o(regw_o), .rd_o(rd_o), .wb_data_o(wb_data_o),
    .fwd_en_o(fwd_en_o), .fwd_rd_o(fwd_rd_o), .fwd_data_o(fwd_data_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic rw, input logic [1:0] src,
                       input logic [31:0] alu, input logic [4:0] rd);
    in_valid = v;
    regw_i   = rw;
    resrc_i  = src;
    alu_i    = alu;
    memd_i   = 32'h22;
    pcp4_i   = 32'h33;
    rd_i     = rd;
  endtask

  task automatic push(input logic rw, input logic [4:0] rd, input logic [31:0] d);
    exp_t e;
    e.regw = rw;
    e.rd   = rd;
    e.data = d;
    exp_q.push_back(e);
  endtask

  // Monitor: every consumed output must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL mon_unexpected: got output 0x%0h expected none", wb_data_o);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("mon_wb_data", wb_data_o, e.data);
        check("mon_rd", {27'd0, rd_o}, {27'd0, e.rd});
        check("mon_regw", {31'd0, regw_o}, {31'd0, e.regw});
        check("mon_fwd_en", {31'd0, fwd_en_o}, {31'd0, e.regw});
        check("mon_fwd_rd", {27'd0, fwd_rd_o}, {27'd0, e.rd});
        check("mon_fwd_data", fwd_data_o, e.data);
      end
    end
  end

  initial begin
    rst_n = 1'b0; flush = 1'b0; out_ready = 1'b0;
    drive(1'b1, 1'b1, 2'b00, 32'h99, 5'd3);
    repeat (3) step();
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_wb_data", wb_data_o, 32'd0);
    check("rst_fwd_en", {31'd0, fwd_en_o}, 32'd0);
    drive(1'b0, 1'b0, 2'b00, 32'h0, 5'd0);
    rst_n = 1'b1;
    step();
    check("rel_in_ready", {31'd0, in_ready}, 32'd1);

    // Source select stream, one output per cycle
    out_ready = 1'b1;
    drive(1'b1, 1'b1, 2'b00, 32'h11, 5'd5); push(1'b1, 5'd5, 32'h11); step();
    check("sel_alu", wb_data_o, 32'h11);
    check("sel_fwd_en", {31'd0, fwd_en_o}, 32'd1);
    check("sel_fwd_rd", {27'd0, fwd_rd_o}, 32'd5);
    drive(1'b1, 1'b1, 2'b01, 32'h11, 5'd5); push(1'b1, 5'd5, 32'h22); step();
    check("sel_mem", wb_data_o, 32'h22);
    drive(1'b1, 1'b1, 2'b10, 32'h11, 5'd5); push(1'b1, 5'd5, 32'h33); step();
    check("sel_pc4", wb_data_o, 32'h33);
    drive(1'b1, 1'b1, 2'b11, 32'h11, 5'd5); push(1'b1, 5'd5, 32'h11); step();
    check("sel_rsv", wb_data_o, 32'h11);
    drive(1'b0, 1'b0, 2'b00, 32'h0, 5'd0); step();
    check("sel_drain", {31'd0, out_valid}, 32'd0);

    // Write to x0 is squashed
    drive(1'b1, 1'b1, 2'b00, 32'hDEAD, 5'd0); push(1'b0, 5'd0, 32'hDEAD); step();
    check("x0_valid", {31'd0, out_valid}, 32'd1);
    check("x0_regw", {31'd0, regw_o}, 32'd0);
    check("x0_fwd_en", {31'd0, fwd_en_o}, 32'd0);
    drive(1'b0, 1'b0, 2'b00, 32'h0, 5'd0); step();

    // Stall: A held, B offered
    out_ready = 1'b0;
    drive(1'b1, 1'b1, 2'b00, 32'hA, 5'd7); push(1'b1, 5'd7, 32'hA); step();
    drive(1'b1, 1'b1, 2'b00, 32'hB, 5'd8); push(1'b1, 5'd8, 32'hB);
    for (int i = 0; i < 4; i++) begin
`ifdef MEM_WB_SKID_EN
      check("stall_in_ready", {31'd0, in_ready}, (i == 0) ? 32'd1 : 32'd0);
`else
      check("stall_in_ready", {31'd0, in_ready}, 32'd0);
`endif
      step();
      check("stall_hold_data", wb_data_o, 32'hA);
      check("stall_hold_valid", {31'd0, out_valid}, 32'd1);
    end
    out_ready = 1'b1;
    step();
    drive(1'b0, 1'b0, 2'b00, 32'h0, 5'd0);
    check("release_b", wb_data_o, 32'hB);
    step();
    check("release_done", {31'd0, out_valid}, 32'd0);

    // Flush during stall drops A, B and C
    out_ready = 1'b0;
    drive(1'b1, 1'b1, 2'b00, 32'hA1, 5'd9); step();
    drive(1'b1, 1'b1, 2'b00, 32'hB1, 5'd10); step();
    drive(1'b1, 1'b1, 2'b00, 32'hC1, 5'd11); flush = 1'b1; step();
    flush = 1'b0;
    drive(1'b0, 1'b0, 2'b00, 32'h0, 5'd0);
    check("flush_valid", {31'd0, out_valid}, 32'd0);
    check("flush_in_ready", {31'd0, in_ready}, 32'd1);
    check("flush_fwd_en", {31'd0, fwd_en_o}, 32'd0);
    check("flush_data_kept", wb_data_o, 32'hA1);
    out_ready = 1'b1;
    step(); step();
    check("flush_no_output", {31'd0, out_valid}, 32'd0);

    // Back-to-back: eight inputs, no bubble
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b1, 2'b00, 32'h100 + i, 5'(i + 1));
      push(1'b1, 5'(i + 1), 32'h100 + i);
      step();
      check("b2b_valid", {31'd0, out_valid}, 32'd1);
      check("b2b_data", wb_data_o, 32'h100 + i);
    end
    drive(1'b0, 1'b0, 2'b00, 32'h0, 5'd0); step();
    check("b2b_end", {31'd0, out_valid}, 32'd0);

    // Reset mid-stall discards the held entry
    out_ready = 1'b0;
    drive(1'b1, 1'b1, 2'b00, 32'h77, 5'd12); step();
    drive(1'b0, 1'b0, 2'b00, 32'h0, 5'd0);
    rst_n = 1'b0; step();
    check("midrst_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_data", wb_data_o, 32'd0);
    rst_n = 1'b1; out_ready = 1'b1;
    step(); step();
    check("midrst_no_output", {31'd0, out_valid}, 32'd0);

    check("scoreboard_empty", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
